// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of the single-request DDR3 ram block.
// One transaction in flight; data has priority with a bounded starvation window for fetches.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_en,
  output logic [28:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read_req,
  output logic        mem_write_req,
  input  logic        mem_read_data_valid,
  input  logic [31:0] mem_read_data,
  input  logic        mem_read_ready,
  input  logic        mem_write_ready,
  input  logic        mem_stall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]  state_r;
  logic        owner_i_r;
  logic [28:0] addr_r;
  logic [31:0] wdata_r;
  logic        err_r;
  logic [SW-1:0] starve_cnt_r;
  logic [TW-1:0] tmo_cnt_r;

  logic        sel_i_s;
  logic [31:0] sel_addr_s;
  logic        sel_we_s;
  logic [31:0] sel_wdata_s;
  logic        illegal_s;
  logic        rd_active_s;
  logic        wr_active_s;
  logic        timeout_hit_s;
  logic        resp_go_s;
  logic [31:0] resp_data_s;
  logic        resp_err_s;

  // Request selection and address legality check for the IDLE sample
  always_comb begin
    sel_i_s     = i_req & (~d_req | (starve_cnt_r == SW'(STARVE_LIMIT)));
    sel_addr_s  = sel_i_s ? i_addr : d_addr;
    sel_we_s    = sel_i_s ? 1'b0 : d_we;
    sel_wdata_s = sel_i_s ? 32'd0 : d_wdata;
    illegal_s   = (sel_addr_s[1:0] != 2'b00) | (sel_addr_s[31:29] != 3'b000);
  end

  // Illegal accesses park one cycle in RD/WR with the ram port held idle
  assign rd_active_s   = (state_r == ST_RD) & ~err_r;
  assign wr_active_s   = (state_r == ST_WR) & ~err_r;
  assign timeout_hit_s = (TIMEOUT_CYCLES != 0) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  assign mem_read_req  = rd_active_s & mem_read_ready;
  assign mem_write_req = wr_active_s & mem_write_ready & ~mem_stall;
  assign mem_en        = mem_read_req | mem_write_req;
  assign mem_addr      = (rd_active_s | wr_active_s) ? addr_r : 29'd0;
  assign mem_wdata     = wr_active_s ? wdata_r : 32'd0;

  // Decide when the active transaction completes and what it returns
  always_comb begin
    resp_go_s   = 1'b0;
    resp_data_s = 32'd0;
    resp_err_s  = 1'b0;
    case (state_r)
      ST_RD: begin
        if (err_r) begin
          resp_go_s  = 1'b1;
          resp_err_s = 1'b1;
        end else if (mem_read_data_valid) begin
          resp_go_s   = 1'b1;
          resp_data_s = mem_read_data;
        end else if (timeout_hit_s) begin
          resp_go_s  = 1'b1;
          resp_err_s = 1'b1;
        end else begin
          resp_go_s = 1'b0;
        end
      end
      ST_WR: begin
        if (err_r) begin
          resp_go_s  = 1'b1;
          resp_err_s = 1'b1;
        end else if (mem_write_req) begin
          resp_go_s = 1'b1;
        end else begin
          resp_go_s = 1'b0;
        end
      end
      default: resp_go_s = 1'b0;
    endcase
  end

  // Arbitration state, latched request, counters and registered port responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_i_r    <= 1'b0;
      addr_r       <= 29'd0;
      wdata_r      <= 32'd0;
      err_r        <= 1'b0;
      starve_cnt_r <= '0;
      tmo_cnt_r    <= '0;
      i_gnt        <= 1'b0;
      d_gnt        <= 1'b0;
      i_rvalid     <= 1'b0;
      d_rvalid     <= 1'b0;
      i_rdata      <= 32'd0;
      d_rdata      <= 32'd0;
      i_err        <= 1'b0;
      d_err        <= 1'b0;
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= 32'd0;
      d_rdata  <= 32'd0;
      i_err    <= 1'b0;
      d_err    <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_req | d_req) begin
            owner_i_r <= sel_i_s;
            addr_r    <= sel_addr_s[28:0];
            wdata_r   <= sel_wdata_s;
            err_r     <= illegal_s;
            i_gnt     <= sel_i_s;
            d_gnt     <= ~sel_i_s;
            state_r   <= sel_we_s ? ST_WR : ST_RD;
            if (sel_i_s || !i_req) begin
              starve_cnt_r <= '0;
            end else if (starve_cnt_r != SW'(STARVE_LIMIT)) begin
              starve_cnt_r <= starve_cnt_r + SW'(1);
            end else begin
              starve_cnt_r <= starve_cnt_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD, ST_WR: begin
          if (resp_go_s) begin
            state_r  <= ST_RESP;
            i_rvalid <= owner_i_r;
            d_rvalid <= ~owner_i_r;
            i_rdata  <= owner_i_r ? resp_data_s : 32'd0;
            d_rdata  <= owner_i_r ? 32'd0 : resp_data_s;
            i_err    <= owner_i_r & resp_err_s;
            d_err    <= ~owner_i_r & resp_err_s;
          end else if (state_r == ST_RD && TIMEOUT_CYCLES != 0) begin
            tmo_cnt_r <= tmo_cnt_r + TW'(1);
          end else begin
            tmo_cnt_r <= tmo_cnt_r;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          tmo_cnt_r <= '0;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=16).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_en, mem_read_req, mem_write_req;
  logic [28:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read_data_valid, mem_read_ready, mem_write_ready, mem_stall;
  logic [31:0] mem_read_data;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_read_data_valid(mem_read_data_valid), .mem_read_data(mem_read_data),
    .mem_read_ready(mem_read_ready), .mem_write_ready(mem_write_ready),
    .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err,
             mem_en, mem_addr, mem_wdata, mem_read_req, mem_write_req};
  endfunction

  // Read and write requests must never be raised together
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (mem_read_req & mem_write_req))
      chk("rw_excl", 32'd1, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] bad_addr [2];
    int cnt;
    logic exp_i;
    rst_n = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_read_data_valid = 1'b0; mem_read_data = 32'd0;
    mem_read_ready = 1'b1; mem_write_ready = 1'b1; mem_stall = 1'b0;
    #1;
    chk("reset_outs", {31'd0, any_out()}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_outs", {31'd0, any_out()}, 32'd0);

    // Single instruction read, data returned two cycles after request
    i_req = 1'b1; i_addr = 32'h0000_0100;
    tick();
    i_req = 1'b0;
    chk("rd_gnt", {30'd0, i_gnt, d_gnt}, 32'd2);
    chk("rd_req", {30'd0, mem_read_req, mem_en}, 32'd3);
    chk("rd_addr", {3'd0, mem_addr}, 32'h0000_0100);
    tick();
    chk("rd_gnt_pulse", {31'd0, i_gnt}, 32'd0);
    chk("rd_req_hold", {31'd0, mem_read_req}, 32'd1);
    tick();
    mem_read_data_valid = 1'b1; mem_read_data = 32'hDEAD_BEEF;
    chk("rd_no_early_rvalid", {31'd0, i_rvalid}, 32'd0);
    tick();
    mem_read_data_valid = 1'b0;
    chk("rd_rvalid", {29'd0, i_rvalid, i_err, d_rvalid}, 32'd4);
    chk("rd_rdata", i_rdata, 32'hDEAD_BEEF);
    chk("rd_req_drop", {31'd0, mem_read_req}, 32'd0);
    tick();
    chk("rd_rvalid_pulse", {31'd0, i_rvalid}, 32'd0);

    // Data write held off by stall for five cycles
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0040; d_wdata = 32'h1234_5678; mem_stall = 1'b1;
    tick();
    d_req = 1'b0; d_we = 1'b0;
    chk("wr_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    chk("wr_stalled0", {31'd0, mem_write_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("wr_stalled", {30'd0, mem_write_req, d_rvalid}, 32'd0);
    end
    tick();
    mem_stall = 1'b0;
    #1;
    chk("wr_req", {30'd0, mem_write_req, mem_en}, 32'd3);
    chk("wr_wdata", mem_wdata, 32'h1234_5678);
    chk("wr_addr", {3'd0, mem_addr}, 32'h0000_0040);
    tick();
    chk("wr_req_once", {31'd0, mem_write_req}, 32'd0);
    chk("wr_ack", {29'd0, d_rvalid, d_err, i_rvalid}, 32'd4);
    chk("wr_rdata", d_rdata, 32'd0);
    tick();

    // Both ports hold read requests: D,D,D,D,I repeating
    i_req = 1'b1; i_addr = 32'h0000_0200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    for (int k = 0; k < 10; k++) begin
      exp_i = (k % 5 == 4);
      tick();
      chk("starve_gnt", {30'd0, i_gnt, d_gnt}, exp_i ? 32'd2 : 32'd1);
      mem_read_data_valid = 1'b1; mem_read_data = 32'hA000_0000 + k;
      tick();
      mem_read_data_valid = 1'b0;
      chk("starve_rvalid", {30'd0, i_rvalid, d_rvalid}, exp_i ? 32'd2 : 32'd1);
      chk("starve_rdata", exp_i ? i_rdata : d_rdata, 32'hA000_0000 + k);
      tick();
    end
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Misaligned and out-of-range data reads are refused without a ram access
    bad_addr[0] = 32'h0000_0042;
    bad_addr[1] = 32'h2000_0000;
    for (int k = 0; k < 2; k++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = bad_addr[k];
      tick();
      d_req = 1'b0;
      chk("ill_gnt", {31'd0, d_gnt}, 32'd1);
      chk("ill_noreq", {30'd0, mem_read_req, mem_en}, 32'd0);
      tick();
      chk("ill_resp", {29'd0, d_rvalid, d_err, mem_read_req}, 32'd6);
      chk("ill_rdata", d_rdata, 32'd0);
      tick();
    end

    // Instruction read with no data ever returned times out after 16 cycles
    i_req = 1'b1; i_addr = 32'h0000_0400;
    tick();
    i_req = 1'b0;
    cnt = 0;
    for (int k = 0; k < 40 && mem_read_req; k++) begin
      cnt++;
      tick();
    end
    chk("tmo_cycles", cnt, 32'd16);
    chk("tmo_resp", {30'd0, i_rvalid, i_err}, 32'd3);
    chk("tmo_rdata", i_rdata, 32'd0);
    tick();

    // Reset asserted mid-read abandons it; a fresh request then completes
    i_req = 1'b1; i_addr = 32'h0000_0500;
    tick();
    i_req = 1'b0;
    chk("rst_rd_active", {31'd0, mem_read_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", {31'd0, any_out()}, 32'd0);
    tick();
    rst_n = 1'b1;
    mem_read_data_valid = 1'b1; mem_read_data = 32'h5555_5555;
    tick();
    mem_read_data_valid = 1'b0;
    chk("rst_no_resp", {31'd0, any_out()}, 32'd0);
    tick();
    chk("rst_no_resp2", {30'd0, i_rvalid, d_rvalid}, 32'd0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0080;
    tick();
    d_req = 1'b0;
    chk("post_rst_gnt", {30'd0, i_gnt, d_gnt}, 32'd1);
    mem_read_data_valid = 1'b1; mem_read_data = 32'hCAFE_F00D;
    tick();
    mem_read_data_valid = 1'b0;
    chk("post_rst_resp", {29'd0, d_rvalid, d_err, i_rvalid}, 32'd4);
    chk("post_rst_rdata", d_rdata, 32'hCAFE_F00D);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the core's instruction-fetch port and data port onto the single request port of the DDR3-backed ram block.
- Sits directly upstream of ram and drives its addr_in, write_data_in, read_req, write_req and en.
- Holds requests until ram accepts them, returns read data or a write acknowledge, and flags illegal or timed-out accesses.
- Only one transaction is outstanding at a time.

Parameters:
- STARVE_LIMIT, 4: maximum number of consecutive data-port grants while an instruction request is pending.
- TIMEOUT_CYCLES, 1024: maximum number of cycles to wait for read_data_valid before returning an error. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  instruction read request
- i_addr  in  32  instruction byte address
- i_gnt  out  1  one-cycle pulse: instruction request accepted
- i_rvalid  out  1  one-cycle pulse: instruction response
- i_rdata  out  32  instruction read data
- i_err  out  1  error flag, valid with i_rvalid
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_addr  in  32  data byte address
- d_wdata  in  32  data write data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: data response (read data, or write acknowledge)
- d_rdata  out  32  data read data (0 for writes)
- d_err  out  1  error flag, valid with d_rvalid
- mem_en  out  1  drives ram en
- mem_addr  out  29  drives ram addr_in
- mem_wdata  out  32  drives ram write_data_in
- mem_read_req  out  1  drives ram read_req
- mem_write_req  out  1  drives ram write_req
- mem_read_data_valid  in  1  from ram read_data_valid
- mem_read_data  in  32  from ram read_data_out
- mem_read_ready  in  1  from ram read_ready
- mem_write_ready  in  1  from ram write_ready
- mem_stall  in  1  from ram please_stall_everything

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0; starvation counter 0; timeout counter 0; latched request cleared. An in-flight transaction is abandoned and no response is emitted.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - i_req and d_req are sampled only in this state.
  - Selection is fixed priority to data, except when starve_cnt==STARVE_LIMIT and i_req=1; then instruction wins.
  - The selected port, address, we and wdata are registered.
  - Next cycle: the matching gnt pulses for one cycle.
- Address check on latch:
  - addr[1:0]!=0 or addr[31:29]!=0 is illegal.
  - Illegal: state goes to RESP with err=1 and rdata=0. No memory access is made.
- Legal read → RD; legal write → WR.
- starve_cnt:
  - Increments on a data grant while i_req=1, saturating at STARVE_LIMIT.
  - Clears on any instruction grant.
  - Clears on a data grant while i_req=0.
- RD:
  - mem_en=1, mem_read_req=1, mem_addr=latched addr[28:0], held stable.
  - mem_read_req and mem_en are asserted only when mem_read_ready=1.
  - Read requests are held through mem_stall=1.
  - On mem_read_data_valid=1: capture mem_read_data, go to RESP, drop mem_read_req the same edge.
  - Timeout counter increments each RD cycle. On reaching TIMEOUT_CYCLES: drop mem_read_req, go to RESP with err=1, rdata=0.
- WR:
  - mem_write_req = mem_en = (mem_write_ready & ~mem_stall). This is combinational from the latched state.
  - mem_wdata and mem_addr are held stable.
  - The write is accepted in the cycle mem_write_req=1; next state is RESP.
  - Writes are posted: the acknowledge does not wait for DDR completion.
- RESP:
  - Pulse the owning port's rvalid with its rdata/err for exactly one cycle.
  - The non-owning port's outputs stay 0.
  - Return to IDLE; the timeout counter clears.
- Latency:
  - Read, valid in cycle N (IDLE sample) → gnt and mem_read_req in N+1. If mem_read_data_valid arrives in cycle M, rvalid is in M+1. Minimum read latency is 3 cycles.
  - Write with ready and no stall → gnt N+1, mem_write_req N+1, rvalid N+2.
  - Illegal access → gnt N+1, rvalid N+2.
- Back-to-back: a requester may hold req high. A new sample is taken in the IDLE following RESP, giving at most 1 transaction per 3 cycles.
- mem_read_req and mem_write_req are never both high. Neither is high outside RD/WR.
- mem_read_data_valid outside RD is ignored.

Test Plan:
- Single instruction read i_addr=0x0000_0100; ram returns 0xDEADBEEF 2 cycles after mem_read_req → i_gnt at +1, mem_addr=0x100, i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0.
- d_req write d_addr=0x40, d_wdata=0x12345678 with mem_stall=1 for 5 cycles → mem_write_req stays 0 until stall drops, then 1 for exactly one cycle with mem_wdata=0x12345678, then d_rvalid=1, d_err=0.
- i_req and d_req (reads) held high continuously with STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D,D,D,D,I; no gnt overlaps.
- d_addr=0x0000_0042 (misaligned) and separately 0x2000_0000 (out of range) → d_gnt, then d_rvalid with d_err=1, d_rdata=0; mem_read_req never asserted.
- Read with mem_read_data_valid never asserted, TIMEOUT_CYCLES=16 → mem_read_req high for 16 cycles then low; i_rvalid=1, i_err=1, i_rdata=0.
- rst_n pulsed low while in RD → all outputs 0 immediately, no rvalid afterwards; a fresh request after reset completes normally.
